// File: rtl/ben_datapath.sv
// ben_datapath: shared 8-bit bus datapath (A, B, IR, 4-bit PC, add/sub ALU) of a Ben-style CPU.
// Define DATAPATH_FLAGS_EN to latch {carry, zero} into a flags register under i_fi.
module ben_datapath (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ai,
   input  logic       i_bi,
   input  logic       i_ii,
   input  logic       i_ao,
   input  logic       i_bo,
   input  logic       i_io,
   input  logic       i_j,
   input  logic       i_co,
   input  logic       i_ce,
   input  logic       i_eo,
   input  logic       i_su,
   input  logic       i_fi,
   input  logic       i_ext_oe,
   input  logic [7:0] i_ext_data,
   output logic [7:0] o_bus,
   output logic       o_conflict,
   output logic [7:0] o_a,
   output logic [7:0] o_b,
   output logic [7:0] o_ir,
   output logic [3:0] o_pc,
   output logic       o_carry,
   output logic       o_zero
);

   logic [7:0] a_q, b_q, ir_q;
   logic [3:0] pc_q;
   logic [8:0] alu_sum;
   logic [7:0] alu_res;
   logic       alu_carry, alu_zero;
   logic [7:0] bus;
   logic [2:0] n_drv;

   // Subtraction is A + ~B + 1, so carry doubles as "no borrow".
   always_comb begin
      alu_sum   = {1'b0, a_q} + {1'b0, (i_su ? ~b_q : b_q)} + {8'h00, i_su};
      alu_res   = alu_sum[7:0];
      alu_carry = alu_sum[8];
      alu_zero  = (alu_res == 8'h00);
   end

   // Active drivers are ORed together; more than one flags a conflict.
   always_comb begin
      bus   = 8'h00;
      n_drv = 3'd0;
      if (i_ao) begin
         bus   = bus | a_q;
         n_drv = n_drv + 3'd1;
      end
      if (i_bo) begin
         bus   = bus | b_q;
         n_drv = n_drv + 3'd1;
      end
      if (i_io) begin
         bus   = bus | {4'h0, ir_q[3:0]};
         n_drv = n_drv + 3'd1;
      end
      if (i_co) begin
         bus   = bus | {4'h0, pc_q};
         n_drv = n_drv + 3'd1;
      end
      if (i_eo) begin
         bus   = bus | alu_res;
         n_drv = n_drv + 3'd1;
      end
      if (i_ext_oe) begin
         bus   = bus | i_ext_data;
         n_drv = n_drv + 3'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_q  <= 8'h00;
         b_q  <= 8'h00;
         ir_q <= 8'h00;
         pc_q <= 4'h0;
      end else begin
         if (i_ai) a_q <= bus;
         if (i_bi) b_q <= bus;
         if (i_ii) ir_q <= bus;
         if (i_j) begin
            pc_q <= bus[3:0];
         end else if (i_ce) begin
            pc_q <= pc_q + 4'h1;
         end
      end
   end

`ifdef DATAPATH_FLAGS_EN
   logic [1:0] flags_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         flags_q <= 2'b00;
      end else if (i_fi) begin
         flags_q <= {alu_carry, alu_zero};
      end
   end

   assign o_carry = flags_q[1];
   assign o_zero  = flags_q[0];
`else
   logic unused_fi;
   assign unused_fi = i_fi;
   assign o_carry   = alu_carry;
   assign o_zero    = alu_zero;
`endif

   assign o_bus      = bus;
   assign o_conflict = (n_drv > 3'd1);
   assign o_a        = a_q;
   assign o_b        = b_q;
   assign o_ir       = ir_q;
   assign o_pc       = pc_q;

endmodule

// File: tb/tb_ben_datapath.sv
// Self-checking bench for ben_datapath: directed scenarios plus random control words,
// all checked against an arithmetic reference model (honours DATAPATH_FLAGS_EN).
module tb_ben_datapath;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ai, bi, ii, ao, bo, io, j, co, ce, eo, su, fi, ext_oe;
   logic [7:0] ext_data;
   logic [7:0] bus, a, b, ir;
   logic       conflict, carry, zero;
   logic [3:0] pc;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [12:0] C_AI  = 13'h0001;
   localparam logic [12:0] C_BI  = 13'h0002;
   localparam logic [12:0] C_II  = 13'h0004;
   localparam logic [12:0] C_AO  = 13'h0008;
   localparam logic [12:0] C_BO  = 13'h0010;
   localparam logic [12:0] C_IO  = 13'h0020;
   localparam logic [12:0] C_J   = 13'h0040;
   localparam logic [12:0] C_CO  = 13'h0080;
   localparam logic [12:0] C_CE  = 13'h0100;
   localparam logic [12:0] C_EO  = 13'h0200;
   localparam logic [12:0] C_SU  = 13'h0400;
   localparam logic [12:0] C_FI  = 13'h0800;
   localparam logic [12:0] C_EXT = 13'h1000;

   // Reference state
   int m_a, m_b, m_ir, m_pc, m_fc, m_fz;

   ben_datapath dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_ai       (ai),
      .i_bi       (bi),
      .i_ii       (ii),
      .i_ao       (ao),
      .i_bo       (bo),
      .i_io       (io),
      .i_j        (j),
      .i_co       (co),
      .i_ce       (ce),
      .i_eo       (eo),
      .i_su       (su),
      .i_fi       (fi),
      .i_ext_oe   (ext_oe),
      .i_ext_data (ext_data),
      .o_bus      (bus),
      .o_conflict (conflict),
      .o_a        (a),
      .o_b        (b),
      .o_ir       (ir),
      .o_pc       (pc),
      .o_carry    (carry),
      .o_zero     (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ctl(input logic [12:0] c, input logic [7:0] d);
      ai = c[0]; bi = c[1]; ii = c[2]; ao = c[3]; bo = c[4]; io = c[5];
      j  = c[6]; co = c[7]; ce = c[8]; eo = c[9]; su = c[10]; fi = c[11];
      ext_oe = c[12]; ext_data = d;
      #1;
   endtask

   task automatic model_alu(output int res, output int cy, output int zf);
      if (su) begin
         res = (m_a - m_b + 256) % 256;
         cy  = (m_a >= m_b) ? 1 : 0;
      end else begin
         res = (m_a + m_b) % 256;
         cy  = (m_a + m_b > 255) ? 1 : 0;
      end
      zf = (res == 0) ? 1 : 0;
   endtask

   task automatic model_bus(output int v, output int clash);
      int drv[$];
      int res, cy, zf;
      model_alu(res, cy, zf);
      if (ao) drv.push_back(m_a);
      if (bo) drv.push_back(m_b);
      if (io) drv.push_back(m_ir % 16);
      if (co) drv.push_back(m_pc);
      if (eo) drv.push_back(res);
      if (ext_oe) drv.push_back(int'(ext_data));
      v = 0;
      foreach (drv[k]) v = v | drv[k];
      clash = (drv.size() > 1) ? 1 : 0;
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_ir = 0; m_pc = 0; m_fc = 0; m_fz = 0;
   endtask

   task automatic check_flags();
      int res, cy, zf;
      model_alu(res, cy, zf);
`ifdef DATAPATH_FLAGS_EN
      check("carry", int'(carry), m_fc);
      check("zero", int'(zero), m_fz);
`else
      check("carry", int'(carry), cy);
      check("zero", int'(zero), zf);
`endif
   endtask

   task automatic check_regs();
      check("a", int'(a), m_a);
      check("b", int'(b), m_b);
      check("ir", int'(ir), m_ir);
      check("pc", int'(pc), m_pc);
   endtask

   // Called with inputs settled between edges; checks combinational outputs, clocks, checks state.
   task automatic step();
      int v, clash, res, cy, zf;
      model_bus(v, clash);
      model_alu(res, cy, zf);
      check("bus", int'(bus), v);
      check("conflict", int'(conflict), clash);
      check_flags();
      @(posedge clk);
      if (ai) m_a = v;
      if (bi) m_b = v;
      if (ii) m_ir = v;
      if (j) m_pc = v % 16;
      else if (ce) m_pc = (m_pc + 1) % 16;
`ifdef DATAPATH_FLAGS_EN
      if (fi) begin
         m_fc = cy;
         m_fz = zf;
      end
`endif
      #1;
      check_regs();
      @(negedge clk);
   endtask

   initial begin
      logic [12:0] c;
      model_reset();

      // Strobes during reset are ignored
      set_ctl(C_AI | C_BI | C_CE | C_EXT, 8'hFF);
      check("rst_bus_ext", int'(bus), 8'hFF);
      @(posedge clk);
      #1;
      check("rst_a_hold", int'(a), 0);
      check("rst_pc_hold", int'(pc), 0);
      @(negedge clk);
      rst = 1'b0;
      set_ctl(13'h0000, 8'h00);
      check("rst_bus", int'(bus), 0);
      check("rst_conflict", int'(conflict), 0);
      check_regs();

      // Load and add
      set_ctl(C_AI | C_EXT, 8'h1C); step();
      set_ctl(C_BI | C_EXT, 8'h0E); step();
      set_ctl(C_EO | C_AI, 8'h00);
      check("add_bus", int'(bus), 8'h2A);
      step();
      check("add_a", int'(a), 8'h2A);

      // Subtract to zero, flags not latched, then latched
      set_ctl(C_AI | C_EXT, 8'h05); step();
      set_ctl(C_BI | C_EXT, 8'h05); step();
      set_ctl(C_EO | C_SU, 8'h00);
      check("sub_bus", int'(bus), 8'h00);
      step();
`ifdef DATAPATH_FLAGS_EN
      check("zero_no_fi", int'(zero), 0);
`endif
      set_ctl(C_EO | C_SU | C_FI, 8'h00); step();
      check("zero_after_fi", int'(zero), 1);

      // Add overflow
      set_ctl(C_AI | C_EXT, 8'hFF); step();
      set_ctl(C_BI | C_EXT, 8'h01); step();
      set_ctl(C_EO | C_FI, 8'h00);
      check("ovf_bus", int'(bus), 8'h00);
      step();
      check("ovf_carry", int'(carry), 1);

      // PC wrap, jump priority, PC on bus
      for (int i = 0; i < 16; i++) begin
         set_ctl(C_CE, 8'h00); step();
      end
      check("pc_wrap", int'(pc), 0);
      set_ctl(C_J | C_CE | C_EXT, 8'hA7); step();
      check("pc_jump", int'(pc), 7);
      set_ctl(C_CO, 8'h00);
      check("co_bus", int'(bus), 8'h07);
      step();

      // IR
      set_ctl(C_II | C_EXT, 8'h5F); step();
      check("ir_load", int'(ir), 8'h5F);
      set_ctl(C_IO, 8'h00);
      check("io_bus", int'(bus), 8'h0F);
      step();

      // Conflict
      set_ctl(C_AI | C_EXT, 8'h30); step();
      set_ctl(C_BI | C_EXT, 8'h03); step();
      set_ctl(C_AO | C_BO, 8'h00);
      check("conf_bus", int'(bus), 8'h33);
      check("conf_flag", int'(conflict), 1);
      step();

      // Self drive and load holds A
      set_ctl(C_AO | C_AI, 8'h00); step();
      check("self_load", int'(a), 8'h30);

      // Asynchronous reset mid-count
      set_ctl(C_J | C_EXT, 8'h00); step();
      for (int i = 0; i < 5; i++) begin
         set_ctl(C_CE, 8'h00); step();
      end
      check("pc_five", int'(pc), 5);
      set_ctl(13'h0000, 8'h00);
      #1 rst = 1'b1;
      #1;
      check("async_pc", int'(pc), 0);
      check("async_a", int'(a), 0);
      check("async_bus", int'(bus), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Random control words
      for (int n = 0; n < 400; n++) begin
         c = 13'h0000;
         if ($urandom_range(0, 2) == 0) c = c | C_AI;
         if ($urandom_range(0, 2) == 0) c = c | C_BI;
         if ($urandom_range(0, 3) == 0) c = c | C_II;
         if ($urandom_range(0, 3) == 0) c = c | C_AO;
         if ($urandom_range(0, 3) == 0) c = c | C_BO;
         if ($urandom_range(0, 4) == 0) c = c | C_IO;
         if ($urandom_range(0, 4) == 0) c = c | C_J;
         if ($urandom_range(0, 4) == 0) c = c | C_CO;
         if ($urandom_range(0, 1) == 0) c = c | C_CE;
         if ($urandom_range(0, 2) == 0) c = c | C_EO;
         if ($urandom_range(0, 1) == 0) c = c | C_SU;
         if ($urandom_range(0, 1) == 0) c = c | C_FI;
         if ($urandom_range(0, 2) == 0) c = c | C_EXT;
         set_ctl(c, 8'($urandom_range(0, 255)));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
